// File: rtl/chimp_pkg.sv
// rtl/chimp_pkg.sv - shared constants, FSM encoding and LFSR step for the chimp board generator
// Ports: none (package). Used by the board generator, the control path and the VGA drawer.
package chimp_pkg;

    localparam int GRID_CELLS_DEF = 40;    // 8 cols x 5 rows
    localparam int MAX_TILES_DEF  = 31;

    // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_DRAW   = 2'd2,
        ST_FINISH = 2'd3
    } gen_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        return {value[14:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/chimp_lfsr16.sv
// rtl/chimp_lfsr16.sv - free-running 16-bit Fibonacci LFSR
// Ports: clk (clock), iKey0 (async active-high reset to SEED), oValue (current LFSR state).
module chimp_lfsr16
    import chimp_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        iKey0,
    output logic [15:0] oValue
);

    always_ff @(posedge clk or posedge iKey0) begin
        if (iKey0) begin
            oValue <= SEED;
        end else begin
            oValue <= lfsr_next(oValue);
        end
    end

endmodule

// File: rtl/chimp_board_gen.sv
// rtl/chimp_board_gen.sv - places up to MAX_TILES tiles on distinct random cells of the board
// Ports: clk, iKey0 (async reset), iStart/iCount (round request and tile count),
//        iRdIdx/oRdCell (position table lookup), oBusy, oDone (round complete pulse),
//        oWrEn/oWrIdx/oWrCell (per-tile placement strobe).
module chimp_board_gen
    import chimp_pkg::*;
#(
    parameter int          GRID_CELLS = GRID_CELLS_DEF,
    parameter int          MAX_TILES  = MAX_TILES_DEF,
    parameter logic [15:0] SEED       = LFSR_SEED_DEF
) (
    input  logic       clk,
    input  logic       iKey0,
    input  logic       iStart,
    input  logic [4:0] iCount,
    input  logic [4:0] iRdIdx,
    output logic [5:0] oRdCell,
    output logic       oBusy,
    output logic       oDone,
    output logic       oWrEn,
    output logic [4:0] oWrIdx,
    output logic [5:0] oWrCell
);

    localparam logic [5:0] CELL_LIMIT = 6'(GRID_CELLS);

    gen_state_t state, state_next;

    logic [15:0]           lfsr_value;
    logic [4:0]            cnt;
    logic [4:0]            k;
    logic [GRID_CELLS-1:0] bitmap;
    logic [5:0]            pos [0:MAX_TILES];

    logic [5:0]            cand;
    logic [63:0]           occ_wide;
    logic [GRID_CELLS-1:0] cand_mask;
    logic                  accept;
    logic                  last_tile;
    logic                  unused_lfsr_hi;

    chimp_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .iKey0  (iKey0),
        .oValue (lfsr_value)
    );

    assign cand           = lfsr_value[5:0];
    assign unused_lfsr_hi = ^lfsr_value[15:6];

    // Widened view lets any 6-bit candidate index the bitmap; cells past
    // the grid read as free but are already rejected by the range test.
    assign occ_wide  = 64'(bitmap);
    assign cand_mask = GRID_CELLS'(1) << cand;
    assign accept    = (state == ST_DRAW) && (cand < CELL_LIMIT) && !occ_wide[cand];
    assign last_tile = (({1'b0, k} + 6'd1) == {1'b0, cnt});

    assign oBusy   = (state != ST_IDLE);
    assign oRdCell = pos[iRdIdx];

    always_ff @(posedge clk or posedge iKey0) begin
        if (iKey0) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        oDone      = 1'b0;
        oWrEn      = 1'b0;
        oWrIdx     = 5'd0;
        oWrCell    = 6'd0;
        case (state)
            ST_IDLE: begin
                if (iStart) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_next = (cnt == 5'd0) ? ST_FINISH : ST_DRAW;
            end
            ST_DRAW: begin
                if (accept) begin
                    oWrEn   = 1'b1;
                    oWrIdx  = k;
                    oWrCell = cand;
                    if (last_tile) begin
                        state_next = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                oDone      = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge iKey0) begin
        if (iKey0) begin
            cnt    <= 5'd0;
            k      <= 5'd0;
            bitmap <= '0;
            for (int i = 0; i <= MAX_TILES; i++) begin
                pos[i] <= 6'd0;
            end
        end else begin
            if (state == ST_IDLE && iStart) begin
                cnt <= iCount;
                k   <= 5'd0;
            end
            if (state == ST_CLEAR) begin
                bitmap <= '0;
            end
            if (accept) begin
                pos[k] <= cand;
                bitmap <= bitmap | cand_mask;
                k      <= k + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_chimp_board_gen.sv
// tb/tb_chimp_board_gen.sv - directed self-checking bench for chimp_board_gen
module tb_chimp_board_gen;

    logic       clk = 1'b0;
    logic       iKey0;
    logic       iStart;
    logic [4:0] iCount;
    logic [4:0] iRdIdx;
    logic [5:0] oRdCell;
    logic       oBusy;
    logic       oDone;
    logic       oWrEn;
    logic [4:0] oWrIdx;
    logic [5:0] oWrCell;

    always #5 clk = ~clk;

    chimp_board_gen dut (
        .clk     (clk),
        .iKey0   (iKey0),
        .iStart  (iStart),
        .iCount  (iCount),
        .iRdIdx  (iRdIdx),
        .oRdCell (oRdCell),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oWrEn   (oWrEn),
        .oWrIdx  (oWrIdx),
        .oWrCell (oWrCell)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    logic [5:0]  cells [0:31];
    logic [39:0] used;
    int          n_wr;
    int          n_done;
    int          lat;

    // Drives one round and records every placement. poke_at > 0 re-pulses
    // iStart (count 7) on that cycle; abort_after > 0 asserts reset once
    // that many tiles have been placed.
    task automatic run_round(input int count, input int poke_at, input int abort_after);
        bit done_seen;
        done_seen = 1'b0;
        n_wr      = 0;
        n_done    = 0;
        lat       = 0;
        used      = '0;
        iCount    = 5'(count);
        iStart    = 1'b1;
        for (int cyc = 1; cyc <= 2000 && !done_seen; cyc++) begin
            @(posedge clk);
            #1;
            iStart = (cyc == poke_at);
            iCount = (cyc == poke_at) ? 5'd7 : 5'(count);
            if (oWrEn) begin
                chk("wr_idx", 32'(oWrIdx), 32'(n_wr));
                chk("wr_cell_range", 32'(oWrCell < 6'd40), 1);
                if (oWrCell < 6'd40) begin
                    chk("wr_cell_distinct", 32'(used[oWrCell]), 0);
                    used[oWrCell] = 1'b1;
                end
                if (n_wr < 32) cells[n_wr] = oWrCell;
                n_wr++;
            end
            if (oDone) begin
                n_done++;
                lat       = cyc;
                done_seen = 1'b1;
            end
            if (abort_after > 0 && n_wr == abort_after) begin
                iKey0 = 1'b1;
                #1;
                chk("abort_busy", 32'(oBusy), 0);
                chk("abort_wren", 32'(oWrEn), 0);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("abort_no_done", 32'(oDone), 0);
                end
                iKey0 = 1'b0;
                return;
            end
        end
        chk("round_done", 32'(done_seen), 1);
        chk("latency_min", 32'(lat >= count + 2), 1);
        @(posedge clk);
        #1;
        chk("idle_busy", 32'(oBusy), 0);
        chk("idle_done", 32'(oDone), 0);
    endtask

    initial begin
        logic [15:0] exp_lfsr;

        iKey0  = 1'b1;
        iStart = 1'b0;
        iCount = 5'd0;
        iRdIdx = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_done", 32'(oDone), 0);
        chk("rst_wren", 32'(oWrEn), 0);
        chk("rst_wridx", 32'(oWrIdx), 0);
        chk("rst_wrcell", 32'(oWrCell), 0);
        chk("rst_lfsr", 32'(dut.lfsr_value), 32'h0000ACE1);
        for (int i = 0; i < 32; i++) begin
            iRdIdx = 5'(i);
            #1;
            chk("rst_rdcell", 32'(oRdCell), 0);
        end

        @(negedge clk);
        iKey0    = 1'b0;
        exp_lfsr = 16'hACE1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            exp_lfsr = ref_step(exp_lfsr);
            chk("lfsr_step", 32'(dut.lfsr_value), 32'(exp_lfsr));
        end

        run_round(1, 0, 0);
        chk("c1_writes", 32'(n_wr), 1);
        chk("c1_dones", 32'(n_done), 1);

        run_round(31, 0, 0);
        chk("c31_writes", 32'(n_wr), 31);
        chk("c31_dones", 32'(n_done), 1);
        for (int i = 0; i < 31; i++) begin
            iRdIdx = 5'(i);
            #1;
            chk("c31_readback", 32'(oRdCell), 32'(cells[i]));
        end

        run_round(0, 0, 0);
        chk("c0_writes", 32'(n_wr), 0);
        chk("c0_dones", 32'(n_done), 1);
        chk("c0_latency", 32'(lat), 2);

        run_round(5, 2, 0);
        chk("poke_writes", 32'(n_wr), 5);
        chk("poke_dones", 32'(n_done), 1);
        for (int i = 0; i < 5; i++) begin
            iRdIdx = 5'(i);
            #1;
            chk("poke_readback", 32'(oRdCell), 32'(cells[i]));
        end

        run_round(20, 0, 10);
        chk("abort_writes", 32'(n_wr), 10);
        chk("abort_dones", 32'(n_done), 0);

        run_round(3, 0, 0);
        chk("after_abort_writes", 32'(n_wr), 3);
        chk("after_abort_dones", 32'(n_done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
